cpipeline_exec_datapath: RTL and testbench

Two-stage execute datapath for the CPipeline CPU core. It combines a 32x32 register file, a MIPS-style ALU-control decoder and a 32-bit ALU. Each cycle it accepts one register-register operation (rs1, rs2, rd, we, alu_op, func), reads the operands, and computes the result. The result is written back to rd one cycle after issue. It sits between instruction decode and the rest of the pipeline.

---
 rtl/cpipeline_pkg.sv | 40 ++++
 rtl/cpipeline_regfile.sv | 32 +++
 rtl/cpipeline_exec_datapath.sv | 106 ++++++++++
 tb/tb_cpipeline_exec_datapath.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpipeline_pkg.sv
// Shared constants for the CPipeline execute datapath: widths, ALU op classes,
// R-type function codes and the ALU control encoding.
package cpipeline_pkg;

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int IDX_W  = $clog2(REG_N);

  // Main-decoder op class; 2'b11 is treated as R-type as well.
  localparam logic [1:0] ALU_OP_MEM    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_NOR = 6'b100111;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_SLT     = 4'b0111,
    ALU_NOR     = 4'b1100,
    ALU_INVALID = 4'b1111
  } alu_ctrl_e;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_ctrl_e         ctrl;
    logic [IDX_W-1:0]  rd;
    logic              we;
  } idex_t;

endpackage

// File: rtl/cpipeline_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// synchronous reset that loads every register with its own index.
module cpipeline_regfile
  import cpipeline_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    raddr1,
  input  logic [IDX_W-1:0]    raddr2,
  output logic [DATA_W-1:0]   rdata1,
  output logic [DATA_W-1:0]   rdata2,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata
);

  logic [DATA_W-1:0] regs [REG_N];

  // NOTE: the array is reset on purpose because reset-to-index is architectural
  // state software relies on; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= DATA_W'(i);
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/cpipeline_exec_datapath.sv
// Two-stage execute datapath: ID (operand read + ALU-control decode) feeding
// EX/WB (ALU, result register, register-file write-back) with EX->ID forwarding.
module cpipeline_exec_datapath
  import cpipeline_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic              we,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        func,
  output logic [31:0]       a,
  output logic [31:0]       b,
  output logic [3:0]        alu_ctrl,
  output logic [31:0]       result,
  output logic              zero
);

  function automatic alu_ctrl_e decode_alu_ctrl(input logic [1:0] op, input logic [5:0] fn);
    alu_ctrl_e c;
    c = ALU_INVALID;
    if (op == ALU_OP_MEM) begin
      c = ALU_ADD;
    end else if (op == ALU_OP_BRANCH) begin
      c = ALU_SUB;
    end else begin
      case (fn)
        FUNC_ADD: c = ALU_ADD;
        FUNC_SUB: c = ALU_SUB;
        FUNC_AND: c = ALU_AND;
        FUNC_OR:  c = ALU_OR;
        FUNC_NOR: c = ALU_NOR;
        FUNC_SLT: c = ALU_SLT;
        default:  c = ALU_INVALID;
      endcase
    end
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] alu_compute(input logic [DATA_W-1:0] x,
                                                    input logic [DATA_W-1:0] y,
                                                    input alu_ctrl_e         c);
    logic [DATA_W-1:0] r;
    r = '0;
    case (c)
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_ADD: r = x + y;
      ALU_SUB: r = x - y;
      ALU_SLT: r = {{(DATA_W-1){1'b0}}, ($signed(x) < $signed(y))};
      ALU_NOR: r = ~(x | y);
      default: r = '0;
    endcase
    return r;
  endfunction

  idex_t             idex;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  alu_ctrl_e         ctrl_next;

  cpipeline_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (idex.we),
    .waddr  (idex.rd),
    .wdata  (alu_y)
  );

  // NOTE: every always_comb output gets a value on every path, so no latches.
  always_comb begin
    alu_y     = alu_compute(idex.a, idex.b, idex.ctrl);
    ctrl_next = decode_alu_ctrl(alu_op, func);
    // The op in EX writes at the coming edge; hand its result straight to ID.
    op_a = (idex.we && (idex.rd == rs1)) ? alu_y : rdata1;
    op_b = (idex.we && (idex.rd == rs2)) ? alu_y : rdata2;
  end

  // NOTE: pipeline state uses non-blocking assignments so every stage samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex   <= '{a: '0, b: '0, ctrl: ALU_AND, rd: '0, we: 1'b0};
      result <= '0;
      zero   <= 1'b1;
    end else begin
      idex   <= '{a: op_a, b: op_b, ctrl: ctrl_next, rd: rd, we: we};
      result <= alu_y;
      zero   <= (alu_y == '0);
    end
  end

  assign a        = idex.a;
  assign b        = idex.b;
  assign alu_ctrl = idex.ctrl;

endmodule

// File: tb/tb_cpipeline_exec_datapath.sv
// Self-checking bench for cpipeline_exec_datapath: directed scenarios plus
// randomized traffic compared against a behavioural register-file model.
module tb_cpipeline_exec_datapath;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        we;
  logic [1:0]  alu_op;
  logic [5:0]  func;
  logic [31:0] a, b, result;
  logic [3:0]  alu_ctrl;
  logic        zero;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: architectural registers plus the one issued op
  // whose result is still outstanding.
  logic [31:0] mregs [32];
  logic [31:0] m_a, m_b, m_result;
  logic [3:0]  m_ctrl;
  logic [4:0]  m_rd;
  logic        m_we, m_zero;

  logic [1:0]  d_op   [7];
  logic [5:0]  d_func [7];
  logic [3:0]  d_ctrl [7];
  logic [31:0] d_res  [7];
  logic [5:0]  funcs  [6];

  cpipeline_exec_datapath dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .we       (we),
    .alu_op   (alu_op),
    .func     (func),
    .a        (a),
    .b        (b),
    .alu_ctrl (alu_ctrl),
    .result   (result),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (f == 6'b100000) return 4'b0010;
    if (f == 6'b100010) return 4'b0110;
    if (f == 6'b100100) return 4'b0000;
    if (f == 6'b100101) return 4'b0001;
    if (f == 6'b100111) return 4'b1100;
    if (f == 6'b101010) return 4'b0111;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] c);
    int signed sx, sy;
    sx = x;
    sy = y;
    if (c == 4'b0000) return x & y;
    if (c == 4'b0001) return x | y;
    if (c == 4'b0010) return x + y;
    if (c == 4'b0110) return x - y;
    if (c == 4'b0111) return (sx < sy) ? 32'd1 : 32'd0;
    if (c == 4'b1100) return ~(x | y);
    return 32'd0;
  endfunction

  // Advance the model by one clock edge: retire the outstanding op (its write
  // is visible to the op issued at the same edge), then issue the current one.
  task automatic model_step();
    logic [31:0] y;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'(i);
      m_a = 0; m_b = 0; m_ctrl = 4'b0000; m_rd = 0; m_we = 1'b0;
      m_result = 0; m_zero = 1'b1;
    end else begin
      y = ref_alu(m_a, m_b, m_ctrl);
      m_result = y;
      m_zero   = (y == 32'd0);
      if (m_we) mregs[m_rd] = y;
      m_a    = mregs[rs1];
      m_b    = mregs[rs2];
      m_ctrl = ref_decode(alu_op, func);
      m_rd   = rd;
      m_we   = we;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_a", a, m_a);
    check("model_b", b, m_b);
    check("model_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m_ctrl});
    check("model_result", result, m_result);
    check("model_zero", {31'd0, zero}, {31'd0, m_zero});
  endtask

  task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic w, input logic [1:0] op, input logic [5:0] f);
    rs1 = s1; rs2 = s2; rd = d; we = w; alu_op = op; func = f;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_zero"}, {31'd0, zero}, 32'd1);
    check({tag, "_alu_ctrl"}, {28'd0, alu_ctrl}, 32'd0);
    check({tag, "_a"}, a, 32'd0);
    check({tag, "_b"}, b, 32'd0);
  endtask

  initial begin
    d_op   = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
    d_func = '{6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000000, 6'b000000, 6'b100000};
    d_ctrl = '{4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b1111, 4'b0110, 4'b0010};
    d_res  = '{32'd0, 32'd3, 32'hFFFF_FFFC, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd3};
    funcs  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};

    // Reset, then idle read of r7/r9.
    rst_n = 1'b0;
    drive(0, 0, 0, 1'b0, 2'b00, 6'd0);
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    drive(7, 9, 0, 1'b0, 2'b00, 6'd0);
    tick();
    check("idle_a", a, 32'd7);
    check("idle_b", b, 32'd9);

    // Add sweep: reg[i] = i + i.
    for (int i = 0; i < 32; i++) begin
      drive(5'(i), 5'(i), 5'(i), 1'b1, 2'b10, 6'b100000);
      tick();
      if (i > 0) check("add_sweep_result", result, 32'(2 * (i - 1)));
    end
    drive(31, 31, 0, 1'b0, 2'b10, 6'b100000);
    tick();
    check("add_sweep_last", result, 32'd62);
    check("reg31_after_add", a, 32'd62);

    // Sub sweep: reg[i] = reg31 - reg[i]; reg31 must hold 62 until its own write.
    for (int i = 0; i < 32; i++) begin
      drive(31, 5'(i), 5'(i), 1'b1, 2'b10, 6'b100010);
      tick();
      check("sub_sweep_reg31_hold", a, 32'd62);
      if (i > 0) check("sub_sweep_result", result, 32'(62 - 2 * (i - 1)));
    end
    drive(31, 30, 0, 1'b0, 2'b10, 6'b100000);
    tick();
    check("sub_last_result", result, 32'd0);
    check("sub_last_zero", {31'd0, zero}, 32'd1);
    check("reg31_after_sub", a, 32'd0);
    check("reg30_after_sub", b, 32'd2);
    drive(0, 16, 0, 1'b0, 2'b10, 6'b100000);
    tick();
    check("reg0_after_sub", a, 32'd62);
    check("reg16_after_sub", b, 32'd30);

    // Back-to-back dependency through forwarding.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(5, 5, 5, 1'b1, 2'b10, 6'b100000);
    tick();
    drive(5, 5, 6, 1'b1, 2'b10, 6'b100000);
    tick();
    check("fwd_a", a, 32'd10);
    check("fwd_b", b, 32'd10);
    drive(6, 5, 0, 1'b0, 2'b10, 6'b100000);
    tick();
    check("fwd_result", result, 32'd20);
    check("fwd_reg6", a, 32'd20);
    check("fwd_reg5", b, 32'd10);

    // Decode/ALU coverage on reg1=1, reg2=2.
    for (int j = 0; j < 7; j++) begin
      drive(1, 2, 0, 1'b0, d_op[j], d_func[j]);
      tick();
      check("decode_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, d_ctrl[j]});
      tick();
      check("decode_result", result, d_res[j]);
    end

    // Reset lands while an add to r3 is in flight: the write is dropped.
    drive(3, 3, 3, 1'b1, 2'b10, 6'b100000);
    tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 1'b0, 2'b00, 6'd0);
    tick();
    check_reset_outputs("midop_reset");
    rst_n = 1'b1;
    drive(3, 3, 0, 1'b0, 2'b00, 6'd0);
    tick();
    check("midop_reg3", a, 32'd3);

    // Randomized traffic with occasional resets, checked against the model.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 4) != 0) ? funcs[$urandom_range(0, 5)] : 6'($urandom_range(0, 63)));
      tick();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
